// File: rtl/mul6_share_arb.sv
// mul6_share_arb: round-robin arbiter sharing one 6x6 unsigned multiplier between two requesters.
// Define MUL6_SHARE_ARB_ACC_EN to give each requester its own accumulator (shared MAC).
module mul6_share_arb #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [5:0]       req0_a,
    input  logic [5:0]       req0_b,
    input  logic             req0_acc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [5:0]       req1_a,
    input  logic [5:0]       req1_b,
    input  logic             req1_acc,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [ACC_W-1:0] resp_data,
    output logic             resp_id,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t           state, state_nx;
    logic             last_id;
    logic             grant_id;
    logic             accept;
    logic             id_q;
    logic [5:0]       a_q, b_q;
    logic [5:0]       sel_a, sel_b;
    logic [11:0]      product;
    logic [ACC_W-1:0] result_q, result_nx;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        grant_id   = (req0_valid && req1_valid) ? ~last_id : ~req0_valid;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && !rst) begin
            req0_ready = req0_valid && !grant_id;
            req1_ready = req1_valid && grant_id;
        end
        accept   = req0_ready || req1_ready;
        sel_a    = grant_id ? req1_a : req0_a;
        sel_b    = grant_id ? req1_b : req0_b;
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = MUL;
            MUL:     state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign product = 12'(a_q) * 12'(b_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_id  <= 1'b1;
            id_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q     <= sel_a;
                b_q     <= sel_b;
                id_q    <= grant_id;
                last_id <= grant_id;
            end
            if (state == MUL) result_q <= result_nx;
        end
    end

`ifdef MUL6_SHARE_ARB_ACC_EN
    logic             acc_q;
    logic [ACC_W-1:0] acc_reg [2];

    always_comb begin
        result_nx = ACC_W'(product);
        if (acc_q) result_nx = acc_reg[id_q] + ACC_W'(product);
    end

    // The accumulator only commits once the consumer has taken the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= 1'b0;
            acc_reg[0] <= '0;
            acc_reg[1] <= '0;
        end else begin
            if (accept) acc_q <= grant_id ? req1_acc : req0_acc;
            if (state == RESP && resp_ready) acc_reg[id_q] <= result_q;
        end
    end
`else
    logic unused_acc;
    assign unused_acc = req0_acc ^ req1_acc;
    assign result_nx  = ACC_W'(product);
`endif

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign resp_data  = result_q;
    assign resp_id    = id_q;

endmodule

// File: tb/tb_mul6_share_arb.sv
// Self-checking bench for mul6_share_arb: transaction-level reference model plus directed and random traffic.
module tb_mul6_share_arb;

    localparam int ACC_W = 16;
`ifdef MUL6_SHARE_ARB_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [5:0]       req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_acc = 1'b0, req1_acc = 1'b0;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic [ACC_W-1:0] resp_data;
    logic             resp_id;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [ACC_W-1:0] log_data [$];
    logic             log_id   [$];

    // Model: cycles since accept (0 = idle), the owed result, and per-requester accumulators.
    int               mdl_t    = 0;
    logic             mdl_last = 1'b1;
    logic [ACC_W-1:0] mdl_data = '0;
    logic             mdl_id   = 1'b0;
    logic [ACC_W-1:0] mdl_acc [2] = '{'0, '0};

    mul6_share_arb #(.ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_acc(req0_acc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_acc(req1_acc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int modelGrant(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 0 : 1;
        return v0 ? 0 : 1;
    endfunction

    function automatic logic [ACC_W-1:0] modelResult(input logic [5:0] a, input logic [5:0] b,
                                                      input logic acc, input logic [ACC_W-1:0] accum);
        logic [ACC_W-1:0] p;
        p = ACC_W'(int'(a) * int'(b));
        return (ACC_EN && acc) ? accum + p : p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timed out at %0t", name, $time);
    endtask

    task automatic applyStimulus(input logic r, input logic v0, input logic [5:0] a0, input logic [5:0] b0,
                                 input logic c0, input logic v1, input logic [5:0] a1, input logic [5:0] b1,
                                 input logic c1, input logic rr);
        rst = r;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_acc = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_acc = c1;
        resp_ready = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        if (busy) timeoutFail("wait_idle");
    endtask

    task automatic waitResponses(input int target);
        int k = 0;
        while (log_data.size() < target && k < 60) begin
            tick();
            k++;
        end
        if (log_data.size() < target) timeoutFail("wait_response");
    endtask

    // One isolated transaction on one port; the response is taken immediately.
    task automatic doTxn(input logic id, input logic [5:0] a, input logic [5:0] b, input logic acc);
        int n;
        waitIdle();
        n = log_data.size();
        if (id) applyStimulus(0, 0, 0, 0, 0, 1, a, b, acc, 1);
        else    applyStimulus(0, 1, a, b, acc, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 6'd63, 6'd63, 0, 0, 6'd63, 6'd63, 0, 1);
        waitResponses(n + 1);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mdl_t      <= 0;
            mdl_last   <= 1'b1;
            mdl_acc[0] <= '0;
            mdl_acc[1] <= '0;
        end else if (mdl_t == 0) begin
            if (req0_valid || req1_valid) begin
                if (modelGrant(req0_valid, req1_valid, mdl_last) == 1) begin
                    mdl_id   <= 1'b1;
                    mdl_last <= 1'b1;
                    mdl_data <= modelResult(req1_a, req1_b, req1_acc, mdl_acc[1]);
                end else begin
                    mdl_id   <= 1'b0;
                    mdl_last <= 1'b0;
                    mdl_data <= modelResult(req0_a, req0_b, req0_acc, mdl_acc[0]);
                end
                mdl_t <= 1;
            end
        end else if (mdl_t == 1) begin
            mdl_t <= 2;
        end else if (resp_ready) begin
            mdl_acc[mdl_id] <= mdl_data;
            mdl_t           <= 0;
        end
    end

    // Compare process: every output checked against the model each cycle.
    always @(negedge clk) begin
        logic e0, e1;
        int   g;
        g  = modelGrant(req0_valid, req1_valid, mdl_last);
        e0 = (mdl_t == 0) && !rst && req0_valid && (g == 0);
        e1 = (mdl_t == 0) && !rst && req1_valid && (g == 1);
        checkOutput("req0_ready", 32'(req0_ready), 32'(e0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(e1));
        checkOutput("resp_valid", 32'(resp_valid), 32'(mdl_t == 2));
        checkOutput("busy", 32'(busy), 32'(mdl_t != 0));
        if (mdl_t == 2) begin
            checkOutput("resp_data", 32'(resp_data), 32'(mdl_data));
            checkOutput("resp_id", 32'(resp_id), 32'(mdl_id));
        end
        if (!rst && resp_valid && resp_ready) begin
            log_data.push_back(resp_data);
            log_id.push_back(resp_id);
        end
    end

    initial begin
        int n;

        // Reset state, with both requesters pushing.
        applyStimulus(1, 1, 6'd63, 6'd63, 0, 1, 6'd1, 6'd1, 0, 1);
        repeat (3) tick();
        checkOutput("rst_req0_ready", 32'(req0_ready), 0);
        checkOutput("rst_req1_ready", 32'(req1_ready), 0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 0);
        checkOutput("rst_resp_data", 32'(resp_data), 0);
        checkOutput("rst_resp_id", 32'(resp_id), 0);
        checkOutput("rst_busy", 32'(busy), 0);

        // Largest product, lone requester 0.
        checkOutput("model_63x63", 32'(modelResult(6'd63, 6'd63, 1'b0, '0)), 3969);
        applyStimulus(0, 1, 6'd63, 6'd63, 0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("max_ready_cycle0", 32'(req0_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        waitResponses(1);
        checkOutput("max_data", 32'(log_data[0]), 3969);
        checkOutput("max_id", 32'(log_id[0]), 0);
        tick();
        checkOutput("max_busy_after", 32'(busy), 0);

        // Continuous contention from reset: grants alternate starting with 0.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        n = log_data.size();
        applyStimulus(0, 1, 6'd7, 6'd9, 0, 1, 6'd5, 6'd12, 0, 1);
        waitResponses(n + 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        if (log_data.size() >= n + 3) begin
            checkOutput("rr_data0", 32'(log_data[n]), 63);
            checkOutput("rr_id0", 32'(log_id[n]), 0);
            checkOutput("rr_data1", 32'(log_data[n+1]), 60);
            checkOutput("rr_id1", 32'(log_id[n+1]), 1);
            checkOutput("rr_data2", 32'(log_data[n+2]), 63);
            checkOutput("rr_id2", 32'(log_id[n+2]), 0);
        end
        waitIdle();

        // Back-pressure on a requester 1 result while requester 0 waits.
        n = log_data.size();
        applyStimulus(0, 0, 0, 0, 0, 1, 6'd3, 6'd4, 0, 0);
        tick();
        applyStimulus(0, 1, 6'd10, 6'd10, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10 && !resp_valid; k++) tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput("bp_data", 32'(resp_data), 12);
            checkOutput("bp_id", 32'(resp_id), 1);
            checkOutput("bp_req0_ready", 32'(req0_ready), 0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        checkOutput("bp_data_release", 32'(resp_data), 12);
        tick();
        checkOutput("bp_grant_after", 32'(req0_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        waitResponses(n + 2);
        if (log_data.size() >= n + 2) begin
            checkOutput("bp_log_data", 32'(log_data[n]), 12);
            checkOutput("bp_next_data", 32'(log_data[n+1]), 100);
            checkOutput("bp_next_id", 32'(log_id[n+1]), 0);
        end
        waitIdle();

        // Reset in the multiply cycle drops the transaction; contention goes to 0 again.
        n = log_data.size();
        applyStimulus(0, 1, 6'd10, 6'd10, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("abort_resp_valid", 32'(resp_valid), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        repeat (4) tick();
        checkOutput("abort_no_response", log_data.size(), n);
        applyStimulus(0, 1, 6'd1, 6'd2, 0, 1, 6'd1, 6'd3, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        waitResponses(n + 1);
        if (log_data.size() >= n + 1) begin
            checkOutput("abort_next_id", 32'(log_id[n]), 0);
            checkOutput("abort_next_data", 32'(log_data[n]), 2);
        end

        // Zero operand; operands scrambled right after the accept edge.
        n = log_data.size();
        doTxn(1'b0, 6'd0, 6'd45, 1'b0);
        if (log_data.size() > n) checkOutput("zero_data", 32'(log_data[n]), 0);

`ifdef MUL6_SHARE_ARB_ACC_EN
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        n = log_data.size();
        doTxn(1'b0, 6'd2, 6'd3, 1'b1);
        doTxn(1'b0, 6'd4, 6'd5, 1'b1);
        doTxn(1'b0, 6'd1, 6'd1, 1'b0);
        doTxn(1'b1, 6'd1, 6'd1, 1'b1);
        if (log_data.size() >= n + 4) begin
            checkOutput("acc_first", 32'(log_data[n]), 6);
            checkOutput("acc_second", 32'(log_data[n+1]), 26);
            checkOutput("acc_restart", 32'(log_data[n+2]), 1);
            checkOutput("acc_req1_untouched", 32'(log_data[n+3]), 1);
        end
`endif

        // Random traffic with occasional reset; the compare process does the checking.
        for (int k = 0; k < 1500; k++) begin
            applyStimulus($urandom_range(63) == 0,
                          $urandom_range(9) < 6, 6'($urandom), 6'($urandom), 1'($urandom),
                          $urandom_range(9) < 6, 6'($urandom), 6'($urandom), 1'($urandom),
                          $urandom_range(9) < 7);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout reached at %0t", $time);
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule

// File: doc/mul6_share_arb.md
# mul6_share_arb

Round-robin arbiter and sequencer that shares one 6x6 unsigned array multiplier (combinational, 12-bit product) between two requesters. Each requester presents an operand pair over a valid/ready handshake. The block registers the operands and captures the product, then returns a tagged result over a valid/ready response channel. It sits between the multiplier datapath and its two client blocks; an optional per-requester accumulator turns it into a shared MAC.

## Interface
- ACC_W, 16, accumulator / response data width (≥12)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 handshake accepted this cycle
- req0_a, req0_b  in  6 each  requester 0 operands, unsigned
- req0_acc  in  1  requester 0: add product to accumulator (macro only)
- req1_valid, req1_ready, req1_a, req1_b, req1_acc  same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  ACC_W  result
- resp_id  out  1  requester that owns resp_data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE: grant one requester with valid high; assert its reqN_ready combinationally in the same cycle. The handshake is valid&ready.
  - Only one requester is valid: grant it.
  - Both are valid: grant the requester other than last_id.
  - On handshake: latch a, b, acc and id; toggle last_id to the granted id; go to MUL.
- MUL: multiplier inputs are driven from the latched operands. At end of cycle, register the product (12 bits, zero-extended to ACC_W) into the result register; go to RESP.
- RESP: resp_valid=1 and resp_data/resp_id are held stable until resp_ready. On resp_valid&resp_ready, go to IDLE.
- reqN_ready is 0 in MUL and RESP. No new accept occurs in the RESP handshake cycle.
- Operands are sampled only on the handshake edge. Requesters may change operands or drop valid at any time before that.
- Reset values: state=IDLE; last_id=1, so requester 0 wins the first contention; resp_valid=0; resp_data=0; resp_id=0; busy=0; both ready=0 while rst is high; accumulators=0.
- Reset asserted mid-transaction: the transaction is discarded with no response. Everything returns to reset values on the next edge.
- Arithmetic: product = a*b, range 0..3969. Accumulation (macro only) wraps modulo 2^ACC_W.

## Timing
- Accept edge = cycle 0. MUL = cycle 1. resp_valid rises in cycle 2. Accept-to-result latency is 2 cycles.
- With resp_ready tied high, throughput is one result per 3 cycles. Next accept is possible in the cycle after the response handshake.
- Back-pressure: each cycle resp_ready is low extends RESP by one cycle. No data change and no new grant during the stall.
- Round-robin: under continuous dual requests, grants alternate 0,1,0,1. A requester waits at most one foreign transaction.
- busy=1 from cycle 1 through the response-handshake cycle.

## Configuration
- MUL6_SHARE_ARB_ACC_EN defined:
  - Each requester owns an ACC_W-bit accumulator.
  - In MUL, if the latched acc=1, result = acc_reg[id] + product; otherwise result = product.
  - acc_reg[id] is loaded with the result on the response handshake, not earlier, in both cases. acc=0 therefore restarts the accumulation.
- Undefined:
  - No accumulator registers.
  - reqN_acc inputs are ignored.
  - resp_data = zero-extended product.
  - Port list is identical in both builds.

## Test plan
- Reset, then req0 a=6'd63 b=6'd63 alone, resp_ready=1. Required: req0_ready=1 in cycle 0, resp_valid in cycle 2, resp_data=3969, resp_id=0, busy low in cycle 3.
- Both requesters valid from reset: req0 7x9, req1 5x12, both held valid. Required: results 63/id0 then 60/id1 then 63/id0; grants alternate.
- Back-pressure: req1 3x4, resp_ready low 4 cycles after resp_valid. Required: resp_data=12 and resp_id=1 stable throughout; both readys low; no second grant until the cycle after the handshake.
- Reset asserted in cycle 1 of a req0 10x10 transaction. Required: no resp_valid; state IDLE; next contention goes to requester 0.
- Zero and operand change: req0 0x45, then change a/b after handshake. Required: resp_data=0, unaffected by post-handshake operand changes.
- MUL6_SHARE_ARB_ACC_EN: req0 2x3 acc=1, 4x5 acc=1, 1x1 acc=0. Required: resp_data 6, 26, 1; accumulator of requester 1 stays 0.
